// File: rtl/asg_cfg_pkg.sv
// Shared definitions for the ASG sequence-slot config bank: register map,
// field widths, the per-slot record and its bus read/write helpers.
package asg_cfg_pkg;

   localparam int unsigned AMP_W   = 14;
   localparam int unsigned PTR_MAX = 32;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned RDLY_W  = 32;
   localparam int unsigned PHASE_W = 2;

   localparam logic [4:0] OFF_AMP_DC = 5'h00;
   localparam logic [4:0] OFF_END    = 5'h04;
   localparam logic [4:0] OFF_STEP   = 5'h08;
   localparam logic [4:0] OFF_START  = 5'h0C;
   localparam logic [4:0] OFF_CYC    = 5'h10;
   localparam logic [4:0] OFF_RDLY   = 5'h14;
   localparam logic [4:0] OFF_PHASE  = 5'h18;

   localparam logic [11:0] ADDR_CTRL    = 12'h400;
   localparam logic [11:0] ADDR_STATUS  = 12'h404;
   localparam logic [11:0] ADDR_BUF_CNT = 12'h408;
   localparam logic [11:0] ADDR_CYC_CNT = 12'h40C;

   // Pointers are held at full 32 bits; bits above RSZ+16 are masked to zero on write.
   typedef struct packed {
      logic [AMP_W-1:0]   amp;
      logic [AMP_W-1:0]   dc;
      logic [PTR_MAX-1:0] end_ptr;
      logic [PTR_MAX-1:0] step;
      logic [PTR_MAX-1:0] start;
      logic [CNT_W-1:0]   ncyc;
      logic [CNT_W-1:0]   rnum;
      logic [RDLY_W-1:0]  rdly;
      logic [PHASE_W-1:0] phase;
   } slot_cfg_t;

   localparam int unsigned SLOT_W = $bits(slot_cfg_t);

   function automatic logic [31:0] ptr_mask(input int unsigned w);
      return (w >= 32) ? '1 : 32'((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [31:0] slot_read(input slot_cfg_t c, input logic [4:0] off);
      logic [31:0] v;
      v = '0;
      case (off)
         OFF_AMP_DC: begin
            v[13:0]  = c.amp;
            v[29:16] = c.dc;
         end
         OFF_END:   v = c.end_ptr;
         OFF_STEP:  v = c.step;
         OFF_START: v = c.start;
         OFF_CYC:   v = {c.rnum, c.ncyc};
         OFF_RDLY:  v = c.rdly;
         OFF_PHASE: v[1:0] = c.phase;
         default:   v = '0;
      endcase
      return v;
   endfunction

   function automatic slot_cfg_t slot_write(input slot_cfg_t c, input logic [4:0] off,
                                            input logic [31:0] d, input logic [31:0] pmask);
      slot_cfg_t n;
      n = c;
      case (off)
         OFF_AMP_DC: begin
            n.amp = d[13:0];
            n.dc  = d[29:16];
         end
         OFF_END:   n.end_ptr = d & pmask;
         OFF_STEP:  n.step    = d & pmask;
         OFF_START: n.start   = d & pmask;
         OFF_CYC: begin
            n.ncyc = d[15:0];
            n.rnum = d[31:16];
         end
         OFF_RDLY:  n.rdly  = d;
         OFF_PHASE: n.phase = d[1:0];
         default:   n = c;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/red_pitaya_asg_cfg_slot.sv
// One sequence slot: software shadow register, active copy and the pending
// flag that requests a lazy shadow->active transfer.
module red_pitaya_asg_cfg_slot
   import asg_cfg_pkg::*;
#(
   parameter int unsigned RSZ = 16
)(
   input  logic              dac_clk_i,
   input  logic              dac_rst_i,
   input  logic              wen_i,
   input  logic [4:0]        off_i,
   input  logic [31:0]       wdata_i,
   input  logic              commit_i,
   input  logic              copy_ok_i,
   output logic              pending_o,
   output logic [SLOT_W-1:0] shadow_o,
   output logic [SLOT_W-1:0] active_o
);

   localparam logic [31:0] PMASK = ptr_mask(RSZ + 16);

   slot_cfg_t shadow;
   slot_cfg_t active;
   logic      pending;
   logic      copy;

   assign copy = pending & copy_ok_i;

   // A copy samples the pre-write shadow, so a racing write stays uncommitted.
   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (wen_i)
            shadow <= slot_write(shadow, off_i, wdata_i, PMASK);
         if (copy)
            active <= shadow;
         if (commit_i)
            pending <= 1'b1;
         else if (copy)
            pending <= 1'b0;
      end
   end

   assign pending_o = pending;
   assign shadow_o  = shadow;
   assign active_o  = active;

endmodule

// File: rtl/red_pitaya_asg_cfg_bank.sv
// Config bank feeding red_pitaya_asg_ch_double_buf: N_BUF shadow/active slots,
// lazy per-slot commit, playing-slot tracking and done-pulse counters.
module red_pitaya_asg_cfg_bank
   import asg_cfg_pkg::*;
#(
   parameter int unsigned RSZ   = 16,
   parameter int unsigned N_BUF = 4
)(
   input  logic                        dac_clk_i,
   input  logic                        dac_rst_i,
   input  logic [11:0]                 sys_addr_i,
   input  logic [31:0]                 sys_wdata_i,
   input  logic                        sys_wen_i,
   input  logic                        sys_ren_i,
   output logic [31:0]                 sys_rdata_o,
   output logic                        sys_ack_o,
   input  logic                        asg_rst_i,
   input  logic                        buf_done_i,
   input  logic                        cyc_done_i,
   output logic [14*N_BUF-1:0]         set_amp_all_o,
   output logic [14*N_BUF-1:0]         set_dc_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]   set_end_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]   set_step_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]   set_start_all_o,
   output logic [16*N_BUF-1:0]         set_ncyc_all_o,
   output logic [16*N_BUF-1:0]         set_rnum_all_o,
   output logic [2*N_BUF-1:0]          set_phase_bits_all_o,
   output logic [32*N_BUF-1:0]         set_rdly_all_o,
   output logic [$clog2(N_BUF)-1:0]    slot_idx_o,
   output logic                        commit_busy_o
);

   localparam int unsigned IW = $clog2(N_BUF);
   localparam int unsigned PW = RSZ + 16;

   logic [IW-1:0]     slot_idx;
   logic [N_BUF-1:0]  pending;
   logic [N_BUF-1:0]  copy_ok;
   logic [N_BUF-1:0]  slot_wen;
   logic [SLOT_W-1:0] shadow_v [N_BUF];
   logic [SLOT_W-1:0] active_v [N_BUF];
   logic              slot_hit;
   logic [IW-1:0]     slot_sel;
   logic              commit;
   logic              clr_buf_cnt;
   logic              clr_cyc_cnt;
   logic [31:0]       buf_cnt;
   logic [31:0]       cyc_cnt;
   logic [31:0]       rd_val;

   assign slot_hit    = (sys_addr_i >> (5 + IW)) == '0;
   assign slot_sel    = sys_addr_i[5 +: IW];
   assign commit      = sys_wen_i && (sys_addr_i == ADDR_CTRL) && sys_wdata_i[0];
   assign clr_buf_cnt = sys_wen_i && (sys_addr_i == ADDR_BUF_CNT);
   assign clr_cyc_cnt = sys_wen_i && (sys_addr_i == ADDR_CYC_CNT);

   // The playing slot and the one queued next must not change under the ASG;
   // on a buf_done edge the window slides forward, so the slot after next is held too.
   always_comb begin
      slot_wen = '0;
      copy_ok  = '1;
      for (int unsigned s = 0; s < N_BUF; s++) begin
         slot_wen[s] = sys_wen_i && slot_hit && (slot_sel == IW'(s));
         if (!asg_rst_i) begin
            if ((IW'(s) == slot_idx) || (IW'(s) == slot_idx + IW'(1)))
               copy_ok[s] = 1'b0;
            if (buf_done_i && (IW'(s) == slot_idx + IW'(2)))
               copy_ok[s] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < N_BUF; g++) begin : g_slot
      slot_cfg_t act;
      logic      ptr_unused;

      red_pitaya_asg_cfg_slot #(
         .RSZ (RSZ)
      ) u_slot (
         .dac_clk_i (dac_clk_i),
         .dac_rst_i (dac_rst_i),
         .wen_i     (slot_wen[g]),
         .off_i     (sys_addr_i[4:0]),
         .wdata_i   (sys_wdata_i),
         .commit_i  (commit),
         .copy_ok_i (copy_ok[g]),
         .pending_o (pending[g]),
         .shadow_o  (shadow_v[g]),
         .active_o  (active_v[g])
      );

      assign act        = slot_cfg_t'(active_v[g]);
      assign ptr_unused = ^{act.end_ptr >> PW, act.step >> PW, act.start >> PW};

      assign set_amp_all_o[14*g +: 14]       = act.amp;
      assign set_dc_all_o[14*g +: 14]        = act.dc;
      assign set_end_all_o[PW*g +: PW]       = act.end_ptr[PW-1:0];
      assign set_step_all_o[PW*g +: PW]      = act.step[PW-1:0];
      assign set_start_all_o[PW*g +: PW]     = act.start[PW-1:0];
      assign set_ncyc_all_o[16*g +: 16]      = act.ncyc;
      assign set_rnum_all_o[16*g +: 16]      = act.rnum;
      assign set_phase_bits_all_o[2*g +: 2]  = act.phase;
      assign set_rdly_all_o[32*g +: 32]      = act.rdly;
   end

   always_comb begin
      rd_val = '0;
      if (slot_hit) begin
         rd_val = slot_read(slot_cfg_t'(shadow_v[slot_sel]), sys_addr_i[4:0]);
      end else begin
         case (sys_addr_i)
            ADDR_STATUS: begin
               rd_val[16 +: N_BUF] = pending;
               rd_val[IW-1:0]      = slot_idx;
            end
            ADDR_BUF_CNT: rd_val = buf_cnt;
            ADDR_CYC_CNT: rd_val = cyc_cnt;
            default:      rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         slot_idx    <= '0;
         buf_cnt     <= '0;
         cyc_cnt     <= '0;
         sys_ack_o   <= 1'b0;
         sys_rdata_o <= '0;
      end else begin
         sys_ack_o   <= sys_wen_i | sys_ren_i;
         sys_rdata_o <= sys_ren_i ? rd_val : '0;

         if (asg_rst_i)
            slot_idx <= '0;
         else if (buf_done_i)
            slot_idx <= slot_idx + IW'(1);

         if (clr_buf_cnt)
            buf_cnt <= {31'd0, buf_done_i};
         else if (buf_done_i)
            buf_cnt <= buf_cnt + 32'd1;

         if (clr_cyc_cnt)
            cyc_cnt <= {31'd0, cyc_done_i};
         else if (cyc_done_i)
            cyc_cnt <= cyc_cnt + 32'd1;
      end
   end

   assign slot_idx_o    = slot_idx;
   assign commit_busy_o = |pending;

endmodule

// File: tb/tb_red_pitaya_asg_cfg_bank.sv
// Bench for red_pitaya_asg_cfg_bank: directed scenarios plus random traffic,
// all checked against a word-level reference model of the register bank.
module tb_red_pitaya_asg_cfg_bank;

   localparam int unsigned RSZ   = 14;
   localparam int unsigned N_BUF = 4;
   localparam int unsigned PW    = RSZ + 16;

   logic                      dac_clk_i = 1'b0;
   logic                      dac_rst_i = 1'b1;
   logic [11:0]               sys_addr_i = '0;
   logic [31:0]               sys_wdata_i = '0;
   logic                      sys_wen_i = 1'b0;
   logic                      sys_ren_i = 1'b0;
   logic [31:0]               sys_rdata_o;
   logic                      sys_ack_o;
   logic                      asg_rst_i = 1'b1;
   logic                      buf_done_i = 1'b0;
   logic                      cyc_done_i = 1'b0;
   logic [14*N_BUF-1:0]       set_amp_all_o;
   logic [14*N_BUF-1:0]       set_dc_all_o;
   logic [PW*N_BUF-1:0]       set_end_all_o;
   logic [PW*N_BUF-1:0]       set_step_all_o;
   logic [PW*N_BUF-1:0]       set_start_all_o;
   logic [16*N_BUF-1:0]       set_ncyc_all_o;
   logic [16*N_BUF-1:0]       set_rnum_all_o;
   logic [2*N_BUF-1:0]        set_phase_bits_all_o;
   logic [32*N_BUF-1:0]       set_rdly_all_o;
   logic [1:0]                slot_idx_o;
   logic                      commit_busy_o;

   red_pitaya_asg_cfg_bank #(
      .RSZ   (RSZ),
      .N_BUF (N_BUF)
   ) dut (
      .dac_clk_i            (dac_clk_i),
      .dac_rst_i            (dac_rst_i),
      .sys_addr_i           (sys_addr_i),
      .sys_wdata_i          (sys_wdata_i),
      .sys_wen_i            (sys_wen_i),
      .sys_ren_i            (sys_ren_i),
      .sys_rdata_o          (sys_rdata_o),
      .sys_ack_o            (sys_ack_o),
      .asg_rst_i            (asg_rst_i),
      .buf_done_i           (buf_done_i),
      .cyc_done_i           (cyc_done_i),
      .set_amp_all_o        (set_amp_all_o),
      .set_dc_all_o         (set_dc_all_o),
      .set_end_all_o        (set_end_all_o),
      .set_step_all_o       (set_step_all_o),
      .set_start_all_o      (set_start_all_o),
      .set_ncyc_all_o       (set_ncyc_all_o),
      .set_rnum_all_o       (set_rnum_all_o),
      .set_phase_bits_all_o (set_phase_bits_all_o),
      .set_rdly_all_o       (set_rdly_all_o),
      .slot_idx_o           (slot_idx_o),
      .commit_busy_o        (commit_busy_o)
   );

   always #5 dac_clk_i = ~dac_clk_i;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: each slot is 7 bus words as software sees them.
   logic [31:0] m_sh  [N_BUF][7];
   logic [31:0] m_act [N_BUF][7];
   bit          m_pend [N_BUF];
   int unsigned m_idx;
   logic [31:0] m_bd, m_cd, m_rdata;
   bit          m_ack, m_rd;

   logic [31:0] n_sh  [N_BUF][7];
   logic [31:0] n_act [N_BUF][7];
   bit          n_pend [N_BUF];
   int unsigned n_idx;
   logic [31:0] n_bd, n_cd, n_rdata;
   bit          n_ack, n_rd;

   function automatic logic [31:0] wmask(input int unsigned w);
      case (w)
         0:       return 32'h3FFF_3FFF;
         1, 2, 3: return 32'((64'd1 << PW) - 64'd1);
         6:       return 32'h0000_0003;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      int unsigned ai, s, w;
      logic [31:0] v;
      ai = int'(a);
      if (ai < 32 * N_BUF) begin
         s = ai / 32;
         w = (ai % 32) / 4;
         if ((ai % 4) == 0 && w < 7) return m_sh[s][w];
         return 32'd0;
      end
      case (ai)
         32'h404: begin
            v = 32'(m_idx);
            for (int unsigned k = 0; k < N_BUF; k++)
               if (m_pend[k]) v = v + (32'd1 << (16 + k));
            return v;
         end
         32'h408: return m_bd;
         32'h40C: return m_cd;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit eligible(input int unsigned s);
      if (asg_rst_i) return 1'b1;
      if (s == m_idx || s == (m_idx + 1) % N_BUF) return 1'b0;
      if (buf_done_i && s == (m_idx + 2) % N_BUF) return 1'b0;
      return 1'b1;
   endfunction

   task automatic compare_all();
      logic [127:0] e_amp, e_dc, e_end, e_step, e_start, e_ncyc, e_rnum, e_ph, e_rdly;
      bit busy;
      e_amp = '0; e_dc = '0; e_end = '0; e_step = '0; e_start = '0;
      e_ncyc = '0; e_rnum = '0; e_ph = '0; e_rdly = '0; busy = 1'b0;
      for (int unsigned s = 0; s < N_BUF; s++) begin
         e_amp[14*s +: 14]   = m_act[s][0][13:0];
         e_dc[14*s +: 14]    = m_act[s][0][29:16];
         e_end[PW*s +: PW]   = m_act[s][1][PW-1:0];
         e_step[PW*s +: PW]  = m_act[s][2][PW-1:0];
         e_start[PW*s +: PW] = m_act[s][3][PW-1:0];
         e_ncyc[16*s +: 16]  = m_act[s][4][15:0];
         e_rnum[16*s +: 16]  = m_act[s][4][31:16];
         e_rdly[32*s +: 32]  = m_act[s][5];
         e_ph[2*s +: 2]      = m_act[s][6][1:0];
         busy = busy | m_pend[s];
      end
      check_eq("ack", 128'(sys_ack_o), 128'(m_ack));
      if (m_rd) check_eq("rdata", 128'(sys_rdata_o), 128'(m_rdata));
      check_eq("slot_idx", 128'(slot_idx_o), 128'(m_idx));
      check_eq("busy", 128'(commit_busy_o), 128'(busy));
      check_eq("amp", 128'(set_amp_all_o), e_amp);
      check_eq("dc", 128'(set_dc_all_o), e_dc);
      check_eq("end", 128'(set_end_all_o), e_end);
      check_eq("step", 128'(set_step_all_o), e_step);
      check_eq("start", 128'(set_start_all_o), e_start);
      check_eq("ncyc", 128'(set_ncyc_all_o), e_ncyc);
      check_eq("rnum", 128'(set_rnum_all_o), e_rnum);
      check_eq("phase", 128'(set_phase_bits_all_o), e_ph);
      check_eq("rdly", 128'(set_rdly_all_o), e_rdly);
   endtask

   task automatic tick();
      int unsigned ai;
      n_sh = m_sh; n_act = m_act; n_pend = m_pend;
      n_idx = m_idx; n_bd = m_bd; n_cd = m_cd;
      ai = int'(sys_addr_i);
      if (dac_rst_i) begin
         for (int unsigned s = 0; s < N_BUF; s++) begin
            n_pend[s] = 1'b0;
            for (int unsigned w = 0; w < 7; w++) begin
               n_sh[s][w] = '0;
               n_act[s][w] = '0;
            end
         end
         n_idx = 0; n_bd = '0; n_cd = '0;
         n_ack = 1'b0; n_rd = 1'b0; n_rdata = '0;
      end else begin
         n_ack   = sys_wen_i | sys_ren_i;
         n_rd    = sys_ren_i;
         n_rdata = m_read(sys_addr_i);
         for (int unsigned s = 0; s < N_BUF; s++)
            if (m_pend[s] && eligible(s)) begin
               n_act[s]  = m_sh[s];
               n_pend[s] = 1'b0;
            end
         if (sys_wen_i) begin
            if (ai < 32 * N_BUF && (ai % 4) == 0 && ((ai % 32) / 4) < 7)
               n_sh[ai / 32][(ai % 32) / 4] = sys_wdata_i & wmask((ai % 32) / 4);
            if (ai == 32'h400 && sys_wdata_i[0])
               for (int unsigned s = 0; s < N_BUF; s++) n_pend[s] = 1'b1;
         end
         n_bd = (sys_wen_i && ai == 32'h408) ? 32'(buf_done_i) : m_bd + 32'(buf_done_i);
         n_cd = (sys_wen_i && ai == 32'h40C) ? 32'(cyc_done_i) : m_cd + 32'(cyc_done_i);
         n_idx = asg_rst_i ? 0 : (buf_done_i ? (m_idx + 1) % N_BUF : m_idx);
      end
      @(posedge dac_clk_i);
      #1;
      m_sh = n_sh; m_act = n_act; m_pend = n_pend;
      m_idx = n_idx; m_bd = n_bd; m_cd = n_cd;
      m_ack = n_ack; m_rd = n_rd; m_rdata = n_rdata;
      compare_all();
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      sys_addr_i = a; sys_wdata_i = d; sys_wen_i = 1'b1;
      tick();
      sys_wen_i = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a);
      sys_addr_i = a; sys_ren_i = 1'b1;
      tick();
      sys_ren_i = 1'b0;
   endtask

   initial begin
      logic [11:0] ra;
      int unsigned pick;

      repeat (3) tick();
      check_eq("rst_start", 128'(set_start_all_o), 128'd0);
      check_eq("rst_ack", 128'(sys_ack_o), 128'd0);
      dac_rst_i = 1'b0;

      wr(12'h02C, 32'h1234_0000);
      rd(12'h02C);
      check_eq("rb_start", 128'(sys_rdata_o), 128'h1234_0000);
      check_eq("rb_ack", 128'(sys_ack_o), 128'd1);

      wr(12'h400, 32'd1);
      tick();
      check_eq("idle_commit_start1", 128'(set_start_all_o[PW +: PW]), 128'h1234_0000);
      check_eq("idle_commit_busy", 128'(commit_busy_o), 128'd0);

      asg_rst_i = 1'b0;
      for (int unsigned s = 0; s < N_BUF; s++) wr(12'(32 * s + 4), $urandom);
      wr(12'h400, 32'd1);
      rd(12'h404);
      check_eq("status_all_pend", 128'(sys_rdata_o), 128'h000F_0000);
      rd(12'h404);
      check_eq("status_01_pend", 128'(sys_rdata_o), 128'h0003_0000);
      buf_done_i = 1'b1;
      repeat (2) tick();
      buf_done_i = 1'b0;
      tick();
      check_eq("drain_busy", 128'(commit_busy_o), 128'd0);

      buf_done_i = 1'b1;
      repeat (3) tick();
      check_eq("idx_before_race", 128'(slot_idx_o), 128'd1);
      wr(12'h400, 32'd1);
      buf_done_i = 1'b0;
      rd(12'h404);
      rd(12'h404);
      check_eq("race_status", 128'(sys_rdata_o), 128'h000C_0002);

      asg_rst_i = 1'b1;
      tick();
      wr(12'h400, 32'd1);
      wr(12'h400, 32'd1);
      rd(12'h404);
      check_eq("commit_beats_copy", 128'(sys_rdata_o), 128'h000F_0000);
      tick();

      wr(12'h000, 32'h0000_1111);
      wr(12'h400, 32'd1);
      wr(12'h000, 32'h0000_2222);
      check_eq("wr_copy_active", 128'(set_amp_all_o[13:0]), 128'h1111);
      check_eq("wr_copy_busy", 128'(commit_busy_o), 128'd0);
      rd(12'h000);

      wr(12'h408, 32'd0);
      wr(12'h40C, 32'd0);
      for (int unsigned i = 0; i < 7; i++) begin
         buf_done_i = (i < 5);
         cyc_done_i = 1'b1;
         tick();
      end
      buf_done_i = 1'b0; cyc_done_i = 1'b0;
      rd(12'h408);
      check_eq("buf_cnt5", 128'(sys_rdata_o), 128'd5);
      rd(12'h40C);
      check_eq("cyc_cnt7", 128'(sys_rdata_o), 128'd7);
      buf_done_i = 1'b1;
      wr(12'h408, 32'hDEAD_BEEF);
      buf_done_i = 1'b0;
      rd(12'h408);
      check_eq("clr_with_pulse", 128'(sys_rdata_o), 128'd1);

      asg_rst_i = 1'b0;
      wr(12'h400, 32'd1);
      dac_rst_i = 1'b1;
      tick();
      dac_rst_i = 1'b0;
      check_eq("rst_mid_amp", 128'(set_amp_all_o), 128'd0);
      check_eq("rst_mid_busy", 128'(commit_busy_o), 128'd0);
      rd(12'h404);
      check_eq("rst_mid_status", 128'(sys_rdata_o), 128'd0);

      for (int unsigned i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) asg_rst_i = ~asg_rst_i;
         dac_rst_i  = ($urandom_range(0, 249) == 0);
         buf_done_i = ($urandom_range(0, 3) == 0);
         cyc_done_i = ($urandom_range(0, 3) == 0);
         pick = $urandom_range(0, 11);
         if (pick < 7)
            ra = 12'(32 * $urandom_range(0, N_BUF - 1) + 4 * $urandom_range(0, 7));
         else if (pick < 9)
            ra = 12'h400;
         else if (pick < 11)
            ra = 12'(32'h404 + 4 * $urandom_range(0, 2));
         else
            ra = ($urandom_range(0, 1) == 0) ? 12'h200 : 12'h022;
         sys_addr_i  = ra;
         sys_wdata_i = $urandom;
         sys_wen_i   = ($urandom_range(0, 2) == 0);
         sys_ren_i   = ($urandom_range(0, 1) == 0);
         tick();
      end
      sys_wen_i = 1'b0; sys_ren_i = 1'b0; dac_rst_i = 1'b0;
      buf_done_i = 1'b0; cyc_done_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
